// File: rtl/line_backing_memory_if.sv
// ---------------------------------------------------------------------------
// line_backing_memory_if
//
// Request/response bundle between the dcache miss/write-back controller
// (master) and the line backing memory (slave).
//
// Signals:
//   enable_i  master->slave  request valid
//   write_i   master->slave  1 = line write, 0 = line read
//   addr_i    master->slave  byte address of the line
//   data_i    master->slave  write data
//   ack_o     slave->master  one-cycle completion pulse
//   data_o    slave->master  read data, valid while ack_o is high for a read
//   busy_o    slave->master  high from acceptance until ack_o falls
//
// The _i/_o suffixes are from the memory's point of view.
// ---------------------------------------------------------------------------
interface line_backing_memory_if #(
  parameter int LINE_BITS = 256,
  parameter int ADDR_W    = 32
);

  logic                 enable_i;
  logic                 write_i;
  logic [ADDR_W-1:0]    addr_i;
  logic [LINE_BITS-1:0] data_i;
  logic                 ack_o;
  logic [LINE_BITS-1:0] data_o;
  logic                 busy_o;

  // Requester side: drives the request, observes completion.
  modport master (
    output enable_i,
    output write_i,
    output addr_i,
    output data_i,
    input  ack_o,
    input  data_o,
    input  busy_o
  );

  // Memory side: samples the request, drives completion.
  modport slave (
    input  enable_i,
    input  write_i,
    input  addr_i,
    input  data_i,
    output ack_o,
    output data_o,
    output busy_o
  );

endinterface

// File: rtl/line_backing_memory.sv
// ---------------------------------------------------------------------------
// line_backing_memory
//
// Backing store for the L1 data cache. Holds DEPTH lines of LINE_BITS bits
// and serves one line read or line write per request. Each request completes
// LATENCY cycles after acceptance with a single-cycle ack, so the dcache miss
// and write-back paths see realistic stall lengths.
//
// Ports:
//   clk_i   clock, all state changes on the rising edge
//   rst_i   asynchronous active-high reset
//   bus     line_backing_memory_if.slave
//             enable_i/write_i/addr_i/data_i : request (sampled in IDLE only)
//             ack_o  : one-cycle completion pulse
//             data_o : read data, updated only on a read commit
//             busy_o : high whenever the FSM is not IDLE
//
// Line index is addr_i[log2(DEPTH)+4:5]; offset bits and bits above the
// index are ignored, so addresses wrap modulo DEPTH lines.
// Reset aborts any request in flight but leaves the array untouched.
// ---------------------------------------------------------------------------
module line_backing_memory #(
  parameter int LINE_BITS = 256,
  parameter int DEPTH     = 512,
  parameter int ADDR_W    = 32,
  parameter int LATENCY   = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  line_backing_memory_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int IDX_LO = 5;
  localparam int IDX_HI = IDX_W + IDX_LO - 1;

  // Last counter value of the WAIT phase; the commit happens on this edge.
  localparam logic [7:0] LAST_COUNT = 8'(LATENCY - 1);

  // Elaboration-time parameter sanity checks.
  if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
    $error("line_backing_memory: LATENCY must be in 1..255");
  end
  if ((1 << IDX_W) != DEPTH) begin : g_bad_depth
    $error("line_backing_memory: DEPTH must be a power of two");
  end
  if (ADDR_W <= IDX_HI + 1) begin : g_bad_addr
    $error("line_backing_memory: ADDR_W too small for DEPTH");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  // Storage array. No reset: contents survive rst_i.
  logic [LINE_BITS-1:0] mem [DEPTH];

  state_t               state_q,  state_d;
  logic [7:0]           count_q,  count_d;
  logic                 wr_q,     wr_d;
  logic [IDX_W-1:0]     idx_q,    idx_d;
  logic [LINE_BITS-1:0] wdata_q,  wdata_d;
  logic [LINE_BITS-1:0] rdata_q,  rdata_d;
  logic                 ack_q,    ack_d;
  logic                 busy_q,   busy_d;
  logic                 mem_we;

  // Offset bits and bits above the line index are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr_i[IDX_LO-1:0], bus.addr_i[ADDR_W-1:IDX_HI+1]};

  // Next-state logic. The request is latched only in IDLE, so anything the
  // requester does with the inputs during WAIT/ACK has no effect.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    mem_we  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.enable_i) begin
          wr_d    = bus.write_i;
          idx_d   = bus.addr_i[IDX_HI:IDX_LO];
          wdata_d = bus.data_i;
          count_d = 8'd0;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (count_q == LAST_COUNT) begin
          // Commit edge: ack becomes visible in the following cycle.
          state_d = ST_ACK;
          ack_d   = 1'b1;
          if (wr_q) begin
            mem_we = 1'b1;
          end else begin
            rdata_d = mem[idx_q];
          end
        end else begin
          count_d = count_q + 8'd1;
        end
      end

      ST_ACK: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // busy is registered alongside the state so it is glitch-free.
    busy_d = (state_d != ST_IDLE);
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      count_q <= 8'd0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  // Array write port. mem_we comes from state_q, which reset forces to IDLE,
  // so an aborted write never reaches the array.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign bus.ack_o  = ack_q;
  assign bus.busy_o = busy_q;
  assign bus.data_o = rdata_q;

endmodule

// File: tb/tb_line_backing_memory.sv
// ---------------------------------------------------------------------------
// tb_line_backing_memory
//
// Directed bench for line_backing_memory with LATENCY=10. Expected read data
// is pushed to a scoreboard queue when a request is accepted and popped when
// ack_o is seen. Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_line_backing_memory;

  localparam int LINE_BITS = 256;
  localparam int DEPTH     = 512;
  localparam int ADDR_W    = 32;
  localparam int LATENCY   = 10;

  typedef struct {
    bit                   is_read;
    logic [LINE_BITS-1:0] data;
  } exp_t;

  logic clk;
  logic rst;

  line_backing_memory_if #(.LINE_BITS(LINE_BITS), .ADDR_W(ADDR_W)) ifc ();

  line_backing_memory #(
    .LINE_BITS (LINE_BITS),
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .LATENCY   (LATENCY)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t                 sb[$];
  logic [LINE_BITS-1:0] last_rd;
  int                   n_checks;
  int                   n_fails;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  // Issue one request, follow it to its ack and verify timing, data, busy,
  // and that exactly one ack pulse occurs. With scramble set, the request
  // inputs are changed to unrelated values during WAIT.
  task automatic issue(input string tag, input bit wr, input logic [31:0] addr,
                       input logic [255:0] wdata, input logic [255:0] exp_rd,
                       input bit scramble);
    exp_t e;
    exp_t got;
    int   k;
    @(negedge clk);
    ifc.enable_i = 1'b1;
    ifc.write_i  = wr;
    ifc.addr_i   = addr;
    ifc.data_i   = wdata;
    @(posedge clk);
    e.is_read = !wr;
    e.data    = exp_rd;
    sb.push_back(e);
    @(negedge clk);
    ifc.enable_i = 1'b0;
    if (scramble) begin
      ifc.write_i = ~wr;
      ifc.addr_i  = 32'h0000_00A0;
      ifc.data_i  = {8{$urandom}};
    end
    check({tag, " busy after accept"}, 256'(ifc.busy_o), 256'(1));
    k = 0;
    forever begin
      if (ifc.ack_o === 1'b1) break;
      if (k >= LATENCY + 3) break;
      if (wr && k == LATENCY / 2)
        check({tag, " data_o held mid-write"}, ifc.data_o, last_rd);
      @(negedge clk);
      k++;
    end
    check({tag, " ack latency"}, 256'(k), 256'(LATENCY));
    check({tag, " busy at ack"}, 256'(ifc.busy_o), 256'(1));
    if (ifc.ack_o === 1'b1) begin
      if (sb.size() > 0) begin
        got = sb.pop_front();
        if (got.is_read) begin
          check({tag, " read data"}, ifc.data_o, got.data);
          last_rd = got.data;
        end else begin
          check({tag, " data_o held at write ack"}, ifc.data_o, last_rd);
        end
      end
    end
    @(negedge clk);
    check({tag, " ack single cycle"}, 256'(ifc.ack_o), 256'(0));
    check({tag, " busy clears"}, 256'(ifc.busy_o), 256'(0));
  endtask

  task automatic applyStimulus();
    logic [255:0] deadbeef;
    logic [255:0] pat_a;
    logic [255:0] pat_b;
    int           k;
    int           gap;
    int           pulses;
    exp_t         e;
    exp_t         got;

    deadbeef = {8{32'hDEAD_BEEF}};
    pat_a    = {4{64'h0123_4567_89AB_CDEF}};
    pat_b    = {16{16'hA5C3}};

    ifc.enable_i = 1'b0;
    ifc.write_i  = 1'b0;
    ifc.addr_i   = '0;
    ifc.data_i   = '0;
    last_rd      = '0;
    rst          = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Preload lines 0 and 3 through the port, then reset again:
    // the contents must survive reset.
    issue("preload0", 1'b1, 32'h0000_0000, 256'h5, '0, 1'b0);
    issue("preload3", 1'b1, 32'h0000_0060, 256'h1, '0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset ack", 256'(ifc.ack_o), 256'(0));
    check("reset busy", 256'(ifc.busy_o), 256'(0));
    check("reset data_o", ifc.data_o, 256'(0));
    @(negedge clk);
    rst = 1'b0;

    issue("read0", 1'b0, 32'h0000_0000, '0, 256'h5, 1'b0);

    issue("wr400", 1'b1, 32'h0000_0400, deadbeef, '0, 1'b0);
    issue("rd400", 1'b0, 32'h0000_0400, '0, deadbeef, 1'b0);

    // Offset bits ignored: 0x3F and 0x20 are both line 1.
    issue("wr3f", 1'b1, 32'h0000_003F, pat_a, '0, 1'b0);
    issue("rd20", 1'b0, 32'h0000_0020, '0, pat_a, 1'b0);

    // 0x4000 is line 512, which wraps to line 0.
    issue("wr4000", 1'b1, 32'h0000_4000, pat_b, '0, 1'b0);
    issue("rd0wrap", 1'b0, 32'h0000_0000, '0, pat_b, 1'b0);

    // Inputs changed during WAIT must not affect the commit. Line 5 (0xA0)
    // is the scramble target and must stay untouched.
    issue("wr5", 1'b1, 32'h0000_00A0, 256'h55, '0, 1'b0);
    issue("wr4scr", 1'b1, 32'h0000_0080, 256'h44, '0, 1'b1);
    issue("rd4scr", 1'b0, 32'h0000_0080, '0, 256'h44, 1'b1);
    issue("rd5", 1'b0, 32'h0000_00A0, '0, 256'h55, 1'b0);
    issue("rd4", 1'b0, 32'h0000_0080, '0, 256'h44, 1'b0);

    // Back-to-back: enable held high across the first ack.
    @(negedge clk);
    ifc.enable_i = 1'b1;
    ifc.write_i  = 1'b0;
    ifc.addr_i   = 32'h0000_0400;
    @(posedge clk);
    e.is_read = 1'b1;
    e.data    = deadbeef;
    sb.push_back(e);
    sb.push_back(e);
    k = 0;
    @(negedge clk);
    while (ifc.ack_o !== 1'b1 && k < LATENCY + 3) begin
      @(negedge clk);
      k++;
    end
    check("b2b first ack latency", 256'(k), 256'(LATENCY));
    if (sb.size() > 0) begin
      got = sb.pop_front();
      check("b2b first read data", ifc.data_o, got.data);
    end
    @(negedge clk);
    check("b2b idle after ack", 256'(ifc.busy_o), 256'(0));
    @(negedge clk);
    check("b2b second accepted", 256'(ifc.busy_o), 256'(1));
    ifc.enable_i = 1'b0;
    gap = 1;
    while (ifc.ack_o !== 1'b1 && gap < 2 * LATENCY + 4) begin
      @(negedge clk);
      gap++;
    end
    check("b2b ack gap", 256'(gap), 256'(LATENCY + 1));
    if (sb.size() > 0) begin
      got = sb.pop_front();
      check("b2b second read data", ifc.data_o, got.data);
      last_rd = got.data;
    end
    @(negedge clk);
    check("b2b no third ack", 256'(ifc.ack_o), 256'(0));

    // Reset in the middle of a write to line 3: no commit, no ack.
    @(negedge clk);
    ifc.enable_i = 1'b1;
    ifc.write_i  = 1'b1;
    ifc.addr_i   = 32'h0000_0060;
    ifc.data_i   = 256'hBAD;
    @(posedge clk);
    @(negedge clk);
    ifc.enable_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort ack", 256'(ifc.ack_o), 256'(0));
    check("abort busy", 256'(ifc.busy_o), 256'(0));
    check("abort data_o", ifc.data_o, 256'(0));
    last_rd = '0;
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < LATENCY + 5; i++) begin
      @(negedge clk);
      if (ifc.ack_o === 1'b1) pulses++;
    end
    check("abort no ack", 256'(pulses), 256'(0));
    issue("rd3 after abort", 1'b0, 32'h0000_0060, '0, 256'h1, 1'b0);
  endtask

  task automatic checkOutput();
    check("scoreboard drained", 256'(sb.size()), 256'(0));
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    applyStimulus();
    checkOutput();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
